// File: rtl/spi_data_gen_if.sv
`timescale 1ns/1ps
// Word handshake between the stimulus generator and the SPI transmitter's
// parallel data input: valid/data from the generator, ready from the transmitter.
interface spi_data_gen_if #(
    parameter int unsigned P_DATA_WIDTH = 8
);
    logic                    valid;
    logic                    ready;
    logic [P_DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/spi_data_gen.sv
`timescale 1ns/1ps
// Burst stimulus generator for the SPI transmitter: counter, LFSR, walking-one
// or constant words over valid/ready, with fixed-length or stop-terminated bursts.
module spi_data_gen #(
    parameter int unsigned P_DATA_WIDTH  = 8,
    parameter int unsigned P_BURST_WIDTH = 8,
    parameter int unsigned P_LFSR_SEED   = 1
) (
    input  logic                     clk_100,
    input  logic                     a_rst_n,
    input  logic                     s_rst,
    input  logic [1:0]               mode,
    input  logic [P_DATA_WIDTH-1:0]  pattern,
    input  logic [P_BURST_WIDTH-1:0] burst_len,
    input  logic                     start_send,
    input  logic                     stop,
    input  logic                     next_count,
    output logic                     busy,
    output logic                     done,
    output logic [P_BURST_WIDTH-1:0] sent_cnt,
    spi_data_gen_if.master           tx
);
    localparam int unsigned W = P_DATA_WIDTH;
    localparam logic [W-1:0] SEED_RAW = W'(P_LFSR_SEED);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [W-1:0] SEED = (SEED_RAW == '0) ? W'(1) : SEED_RAW;

    localparam logic [1:0] M_CNT   = 2'd0;
    localparam logic [1:0] M_LFSR  = 2'd1;
    localparam logic [1:0] M_WALK  = 2'd2;
    localparam logic [1:0] M_CONST = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    state_t                   state_reg, state_next;
    logic [1:0]               mode_reg, mode_next;
    logic [W-1:0]             pattern_reg, pattern_next;
    logic [P_BURST_WIDTH-1:0] burst_len_reg, burst_len_next;
    logic [P_BURST_WIDTH-1:0] sent_cnt_reg, sent_cnt_next;
    logic [W-1:0]             data_reg, data_next;
    logic                     stop_reg, stop_next;
    logic [W-1:0]             cnt_reg, cnt_next;
    logic [W-1:0]             lfsr_reg, lfsr_next;
    logic [W-1:0]             walk_reg, walk_next;

    logic                     send_valid;
    logic                     hs;
    logic                     last_word;
    logic                     adv_en;
    logic                     lfsr_fb;
    logic [W-1:0]             cnt_step, lfsr_step, walk_step;
    logic [W-1:0]             step_data, start_data;
    logic [P_BURST_WIDTH-1:0] sent_inc;

    generate
        if (W == 8) begin : g_lfsr8
            assign lfsr_fb = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];
        end else if (W == 16) begin : g_lfsr16
            assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[14] ^ lfsr_reg[12] ^ lfsr_reg[3];
        end else if (W == 32) begin : g_lfsr32
            assign lfsr_fb = lfsr_reg[31] ^ lfsr_reg[21] ^ lfsr_reg[1] ^ lfsr_reg[0];
        end else begin : g_lfsr_bad
            $error("spi_data_gen: LFSR pattern supports P_DATA_WIDTH of 8, 16 or 32 only");
            assign lfsr_fb = 1'b0;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_walk
            assign walk_step[gi] = walk_reg[(gi + W - 1) % W];
        end
    endgenerate

    assign cnt_step  = cnt_reg + 1'b1;
    assign lfsr_step = {lfsr_reg[W-2:0], lfsr_fb};
    assign sent_inc  = sent_cnt_reg + 1'b1;

    assign hs        = send_valid && tx.ready;
    assign last_word = ((burst_len_reg != '0) && (sent_inc == burst_len_reg)) || stop || stop_reg;
    // start_send outranks next_count, so an IDLE step only happens without a start.
    assign adv_en    = ((state_reg == S_IDLE) && !start_send && next_count) ||
                       ((state_reg == S_SEND) && hs);

    always_comb begin
        step_data = pattern_reg;
        case (mode_reg)
            M_CNT:   step_data = cnt_step;
            M_LFSR:  step_data = lfsr_step;
            M_WALK:  step_data = walk_step;
            default: step_data = pattern_reg;
        endcase
    end

    always_comb begin
        start_data = pattern;
        case (mode)
            M_CNT:   start_data = cnt_reg;
            M_LFSR:  start_data = lfsr_reg;
            M_WALK:  start_data = walk_reg;
            default: start_data = pattern;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start_send) state_next = S_SEND;
            S_SEND:  if (hs && last_word) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (s_rst) state_next = S_IDLE;
    end

    // FSM: outputs
    always_comb begin
        send_valid = (state_reg == S_SEND);
        busy       = (state_reg == S_SEND);
        done       = (state_reg == S_DONE);
    end

    always_comb begin
        mode_next      = mode_reg;
        pattern_next   = pattern_reg;
        burst_len_next = burst_len_reg;
        sent_cnt_next  = sent_cnt_reg;
        data_next      = data_reg;
        stop_next      = stop_reg;
        cnt_next       = cnt_reg;
        lfsr_next      = lfsr_reg;
        walk_next      = walk_reg;

        if (adv_en) begin
            case (mode_reg)
                M_CNT:   cnt_next  = cnt_step;
                M_LFSR:  lfsr_next = lfsr_step;
                M_WALK:  walk_next = walk_step;
                default: ;
            endcase
        end

        case (state_reg)
            S_IDLE: begin
                if (start_send) begin
                    mode_next      = mode;
                    pattern_next   = pattern;
                    burst_len_next = burst_len;
                    sent_cnt_next  = '0;
                    data_next      = start_data;
                end
            end
            S_SEND: begin
                if (hs) begin
                    sent_cnt_next = sent_inc;
                    // The final word stays on data after the burst ends.
                    if (!last_word) data_next = step_data;
                end else if (stop) begin
                    stop_next = 1'b1;
                end
            end
            S_DONE:  stop_next = 1'b0;
            default: ;
        endcase

        if (s_rst) begin
            mode_next      = M_CNT;
            pattern_next   = '0;
            burst_len_next = '0;
            sent_cnt_next  = '0;
            data_next      = '0;
            stop_next      = 1'b0;
            cnt_next       = '0;
            lfsr_next      = SEED;
            walk_next      = W'(1);
        end
    end

    always_ff @(posedge clk_100 or negedge a_rst_n) begin
        if (!a_rst_n) begin
            mode_reg      <= M_CNT;
            pattern_reg   <= '0;
            burst_len_reg <= '0;
            sent_cnt_reg  <= '0;
            data_reg      <= '0;
            stop_reg      <= 1'b0;
            cnt_reg       <= '0;
            lfsr_reg      <= SEED;
            walk_reg      <= W'(1);
        end else begin
            mode_reg      <= mode_next;
            pattern_reg   <= pattern_next;
            burst_len_reg <= burst_len_next;
            sent_cnt_reg  <= sent_cnt_next;
            data_reg      <= data_next;
            stop_reg      <= stop_next;
            cnt_reg       <= cnt_next;
            lfsr_reg      <= lfsr_next;
            walk_reg      <= walk_next;
        end
    end

    assign tx.valid = send_valid;
    assign tx.data  = data_reg;
    assign sent_cnt = sent_cnt_reg;
endmodule

// File: tb/tb_spi_data_gen.sv
`timescale 1ns/1ps
// Self-checking bench for spi_data_gen: directed and randomized bursts compared
// against a word-level pattern model; outputs sampled on the falling edge.
module tb_spi_data_gen;
    localparam int DW   = 8;
    localparam int BW   = 8;
    localparam int MASK = (1 << DW) - 1;

    logic          clk_100 = 1'b0;
    logic          a_rst_n;
    logic          s_rst;
    logic [1:0]    mode;
    logic [DW-1:0] pattern;
    logic [BW-1:0] burst_len;
    logic          start_send;
    logic          stop;
    logic          next_count;
    logic          busy;
    logic          done;
    logic [BW-1:0] sent_cnt;

    spi_data_gen_if #(.P_DATA_WIDTH(DW)) bus ();

    spi_data_gen #(.P_DATA_WIDTH(DW), .P_BURST_WIDTH(BW), .P_LFSR_SEED(1)) dut (
        .clk_100    (clk_100),
        .a_rst_n    (a_rst_n),
        .s_rst      (s_rst),
        .mode       (mode),
        .pattern    (pattern),
        .burst_len  (burst_len),
        .start_send (start_send),
        .stop       (stop),
        .next_count (next_count),
        .busy       (busy),
        .done       (done),
        .sent_cnt   (sent_cnt),
        .tx         (bus)
    );

    always #5 clk_100 = ~clk_100;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pattern model: one value per generator plus the mode chosen at the last start.
    int m_cnt, m_lfsr, m_walk, m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_adv(input int v);
        int taps[4] = '{8, 6, 5, 4};
        int fb = 0;
        foreach (taps[i]) fb ^= (v >> (taps[i] - 1)) & 1;
        return ((v << 1) | fb) & MASK;
    endfunction

    function automatic int model_word(input int md, input int pat);
        case (md)
            0:       return m_cnt;
            1:       return m_lfsr;
            2:       return m_walk;
            default: return pat;
        endcase
    endfunction

    task automatic model_adv(input int md);
        case (md)
            0:       m_cnt  = (m_cnt + 1) % (MASK + 1);
            1:       m_lfsr = lfsr_adv(m_lfsr);
            2:       m_walk = ((m_walk << 1) | (m_walk >> (DW - 1))) & MASK;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_cnt = 0; m_lfsr = 1; m_walk = 1; m_mode = 0;
    endtask

    // One burst: stop_idx >= 0 raises stop while that word index is presented,
    // holding ready low for two cycles around it.
    task automatic run_burst(input int md, input int pat, input int len, input int stop_idx,
                             input logic [7:0] rdy_pat, input bit rnd, input bit with_next);
        int exp_q[$];
        int n_exp, k, ri, stall, cyc;
        bit stop_sent, prev_stall, rdy;
        logic [DW-1:0] prev_data;
        k = 0; ri = 0; stall = 0; cyc = 0;
        stop_sent = 0; prev_stall = 0; prev_data = '0;
        n_exp = (stop_idx >= 0 && (len == 0 || stop_idx < len)) ? stop_idx + 1 : len;
        m_mode = md;
        for (int i = 0; i < n_exp; i++) begin
            exp_q.push_back(model_word(md, pat));
            model_adv(md);
        end
        mode = md[1:0]; pattern = pat[DW-1:0]; burst_len = len[BW-1:0];
        start_send = 1'b1; next_count = with_next;
        @(posedge clk_100);
        @(negedge clk_100);
        start_send = 1'b0; next_count = 1'b0;
        check("start_valid", bus.valid, 1);
        check("start_busy", busy, 1);
        while (bus.valid === 1'b1 && cyc < 3000) begin
            if (prev_stall) check("hold_data", bus.data, prev_data);
            stop = 1'b0;
            if (stop_idx >= 0 && k == stop_idx && !stop_sent) begin
                stop = 1'b1; stop_sent = 1; stall = 2;
            end
            if (stall > 0) begin
                rdy = 0; stall--;
            end else if (rnd) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = rdy_pat[ri % 8]; ri++;
            end
            bus.ready = rdy;
            if (rdy) begin
                if (k < n_exp) check("word", bus.data, exp_q[k]);
                else check("extra_word", k, n_exp);
                k++;
            end
            prev_stall = !rdy; prev_data = bus.data;
            @(negedge clk_100);
            cyc++;
        end
        bus.ready = 1'b0; stop = 1'b0;
        if (bus.valid !== 1'b0) check("burst_end", bus.valid, 0);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("word_count", k, n_exp);
        check("sent_cnt", sent_cnt, n_exp % (1 << BW));
        if (n_exp > 0) check("data_hold", bus.data, exp_q[n_exp - 1]);
        $display("burst mode=%0d len=%0d stop_idx=%0d words=%0d", md, len, stop_idx, k);
        @(negedge clk_100);
        check("done_once", done, 0);
        check("idle_valid", bus.valid, 0);
    endtask

    initial begin
        int md, len, sidx;
        a_rst_n = 1'b0; s_rst = 1'b0; mode = '0; pattern = '0; burst_len = '0;
        start_send = 1'b0; stop = 1'b0; next_count = 1'b0; bus.ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_100);
        check("rst_valid", bus.valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sent", sent_cnt, 0);
        check("rst_data", bus.data, 0);
        a_rst_n = 1'b1;
        @(negedge clk_100);

        run_burst(0, 0, 4, -1, 8'hFF, 0, 0);   // counter 0..3
        run_burst(0, 0, 3, -1, 8'hE9, 0, 0);   // ready 1,0,0,1,0,1
        run_burst(1, 0, 5, -1, 8'hFF, 0, 0);   // LFSR 01,02,04,08,11
        run_burst(2, 0, 9, -1, 8'hFF, 0, 0);   // walking one wraps
        run_burst(0, 0, 0, 5, 8'hFF, 0, 0);    // continuous, stop on 6th word
        run_burst(0, 0, 0, 259, 8'hFF, 0, 0);  // sent_cnt wraps

        for (int i = 0; i < 3; i++) begin
            next_count = 1'b1;
            @(negedge clk_100);
            next_count = 1'b0;
            model_adv(m_mode);
            @(negedge clk_100);
        end
        run_burst(0, 0, 2, -1, 8'hFF, 0, 0);
        run_burst(0, 0, 2, -1, 8'hFF, 0, 1);   // start + next_count together

        stop = 1'b1;                            // stop in IDLE is ignored
        @(negedge clk_100);
        stop = 1'b0;
        run_burst(3, int'($urandom_range(0, MASK)), 3, -1, 8'hFF, 1, 0);

        for (int i = 0; i < 10; i++) begin
            md  = $urandom_range(0, 3);
            len = $urandom_range(0, 10);
            if (len == 0) sidx = $urandom_range(0, 8);
            else sidx = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len + 2)) : -1;
            if ($urandom_range(0, 1) != 0) begin
                next_count = 1'b1;
                @(negedge clk_100);
                next_count = 1'b0;
                model_adv(m_mode);
            end
            run_burst(md, int'($urandom_range(0, MASK)), len, sidx, 8'hFF, 1, 0);
        end

        // Asynchronous reset in the middle of a stalled burst.
        mode = 2'd0; burst_len = 8'd20; start_send = 1'b1;
        @(posedge clk_100);
        @(negedge clk_100);
        start_send = 1'b0; bus.ready = 1'b0;
        @(negedge clk_100);
        #2 a_rst_n = 1'b0;
        #1;
        check("arst_valid", bus.valid, 0);
        check("arst_busy", busy, 0);
        @(negedge clk_100);
        check("arst_done", done, 0);
        check("arst_data", bus.data, 0);
        check("arst_sent", sent_cnt, 0);
        a_rst_n = 1'b1;
        model_reset();
        @(negedge clk_100);
        check("arst_no_done", done, 0);
        run_burst(0, 0, 2, -1, 8'hFF, 0, 0);
        run_burst(2, 0, 2, -1, 8'hFF, 0, 0);
        run_burst(1, 0, 2, -1, 8'hFF, 0, 0);

        // Synchronous clear beats a simultaneous start.
        s_rst = 1'b1; start_send = 1'b1; mode = 2'd2; burst_len = 8'd4;
        @(negedge clk_100);
        s_rst = 1'b0; start_send = 1'b0;
        model_reset();
        check("srst_valid", bus.valid, 0);
        check("srst_busy", busy, 0);
        check("srst_sent", sent_cnt, 0);
        check("srst_data", bus.data, 0);
        @(negedge clk_100);
        check("srst_idle", bus.valid, 0);
        check("srst_done", done, 0);
        next_count = 1'b1;
        @(negedge clk_100);
        next_count = 1'b0;
        model_adv(m_mode);
        run_burst(0, 0, 1, -1, 8'hFF, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
